instr_fetch: RTL

- Fetch stage of the RV32I core. Sits directly upstream of decode, which feeds instruction bits into the immediate sign-extend unit.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Registers each returned instruction and its PC, and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch.sv | 66 ++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_pkg : shared core types and constants (rev 1.0)        |
// +--------------------------------------------------------------------+
package instr_fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      START = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_if : imem, decode and redirect signals (rev 1.0)       |
// +--------------------------------------------------------------------+
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc;

   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc,
      input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc,
      output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
   );

endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch : RV32I fetch stage, PC + imem req/ack + decode handoff |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = instr_fetch_pkg::NOP_INSTR
) (
   input  wire           clk,
   input  wire           rst_n,
   instr_fetch_if.master bus
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;

   // Redirect targets are word aligned; the low bits are dropped on purpose.
   logic [1:0] w_unused_redirect_lo;
   assign w_unused_redirect_lo = bus.redirect_pc[1:0];

   // Memory request decoded only from flops: no input-to-output path.
   assign bus.imem_req  = (r_state == FETCH);
   assign bus.imem_addr = r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= START;
         r_pc         <= RESET_PC;
         bus.id_valid <= 1'b0;
         bus.id_instr <= NOP_INSTR;
         bus.id_pc    <= RESET_PC;
      end else if (bus.redirect) begin
         r_pc         <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         bus.id_valid <= 1'b0;
         r_state      <= FETCH;
      end else begin
         case (r_state)
            START: r_state <= FETCH;
            FETCH: begin
               if (bus.imem_ack) begin
                  bus.id_instr <= bus.imem_rdata;
                  bus.id_pc    <= r_pc;
                  r_pc         <= r_pc + PC_STEP;
                  bus.id_valid <= 1'b1;
                  r_state      <= VALID;
               end
            end
            VALID: begin
               if (bus.id_ready) begin
                  bus.id_valid <= 1'b0;
                  r_state      <= FETCH;
               end
            end
            default: begin
               bus.id_valid <= 1'b0;
               r_state      <= START;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
